// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants and small helpers used by the register and RAM blocks.
package cpu_pkg;

  localparam int WORD_W = 16;

  // Bits needed to count 0..2*stages held words.
  function automatic int occ_width(input int stages);
    return $clog2(2 * stages + 1);
  endfunction

endpackage

// File: rtl/skid_stage.sv
// One two-entry skid buffer: main entry drives the output, skid entry absorbs
// the word that arrives while the output is stalled, so in_ready is a flop.
module skid_stage
  import cpu_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] main_data_r;
  logic [WIDTH-1:0] skid_data_r;
  logic             main_valid_r;
  logic             skid_valid_r;
  logic             ready_r;

  logic [WIDTH-1:0] main_data_s;
  logic [WIDTH-1:0] skid_data_s;
  logic             main_valid_s;
  logic             skid_valid_s;
  logic             ready_s;
  logic             in_fire_s;
  logic             out_fire_s;

  assign in_fire_s  = in_valid && ready_r;
  assign out_fire_s = main_valid_r && out_ready;

  // Next-state for both entries; flush drops valid flags but keeps data.
  always_comb begin
    main_data_s  = main_data_r;
    skid_data_s  = skid_data_r;
    main_valid_s = main_valid_r;
    skid_valid_s = skid_valid_r;
    if (flush) begin
      main_valid_s = 1'b0;
      skid_valid_s = 1'b0;
    end else if (!main_valid_r || out_fire_s) begin
      if (skid_valid_r) begin
        main_data_s  = skid_data_r;
        main_valid_s = 1'b1;
        skid_valid_s = 1'b0;
      end else if (in_fire_s) begin
        main_data_s  = in_data;
        main_valid_s = 1'b1;
      end else begin
        main_valid_s = 1'b0;
      end
    end else if (in_fire_s) begin
      skid_data_s  = in_data;
      skid_valid_s = 1'b1;
    end else begin
      skid_valid_s = skid_valid_r;
    end
    ready_s = !skid_valid_s;
  end

  // Entry registers; ready stays low through reset and rises on the first edge after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_data_r  <= {WIDTH{1'b0}};
      skid_data_r  <= {WIDTH{1'b0}};
      main_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
      ready_r      <= 1'b0;
    end else begin
      main_data_r  <= main_data_s;
      skid_data_r  <= skid_data_s;
      main_valid_r <= main_valid_s;
      skid_valid_r <= skid_valid_s;
      ready_r      <= ready_s;
    end
  end

  assign in_ready  = ready_r;
  assign out_data  = main_data_r;
  assign out_valid = main_valid_r;

endmodule

// File: rtl/elastic_register.sv
// WIDTH-bit, STAGES-deep elastic pipeline register built from cascaded skid
// stages, with a registered count of the words currently held.
module elastic_register
  import cpu_pkg::*;
#(
  parameter int WIDTH  = WORD_W,
  parameter int STAGES = 1,
  parameter int CNT_W  = occ_width(STAGES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] occupancy
);

  logic [WIDTH-1:0] data_c  [STAGES+1];
  logic             valid_c [STAGES+1];
  logic             ready_c [STAGES+1];
  logic [CNT_W-1:0] occ_r;
  logic [CNT_W-1:0] occ_s;
  logic             in_fire_s;
  logic             out_fire_s;

  assign data_c[0]       = in_data;
  assign valid_c[0]      = in_valid;
  assign ready_c[STAGES] = out_ready;

  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      skid_stage #(
        .WIDTH(WIDTH)
      ) u_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_data  (data_c[k]),
        .in_valid (valid_c[k]),
        .in_ready (ready_c[k]),
        .out_data (data_c[k+1]),
        .out_valid(valid_c[k+1]),
        .out_ready(ready_c[k+1])
      );
    end
  endgenerate

  assign in_ready   = ready_c[0];
  assign out_data   = data_c[STAGES];
  assign out_valid  = valid_c[STAGES];
  assign in_fire_s  = in_valid && ready_c[0];
  assign out_fire_s = valid_c[STAGES] && out_ready;

  // Occupancy next value: flush clears, a balanced in/out pair leaves it unchanged.
  always_comb begin
    occ_s = occ_r;
    if (flush) begin
      occ_s = {CNT_W{1'b0}};
    end else if (in_fire_s && !out_fire_s) begin
      occ_s = occ_r + CNT_W'(1);
    end else if (out_fire_s && !in_fire_s) begin
      occ_s = occ_r - CNT_W'(1);
    end else begin
      occ_s = occ_r;
    end
  end

  // Occupancy register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_r <= {CNT_W{1'b0}};
    end else begin
      occ_r <= occ_s;
    end
  end

  assign occupancy = occ_r;

endmodule
